// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Iterative restoring divider. Divides a 2*WIDTH-bit dividend by
//             a WIDTH-bit divisor, one quotient bit per clock. It produces a
//             WIDTH-bit quotient and remainder, plus divide-by-zero and
//             overflow flags.
//  Options  : DIV_SIGNED_EN - when defined, operands are two's complement.
//             The quotient truncates toward zero and the remainder takes the
//             sign of the dividend. When undefined, operands are unsigned.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               div_zero,
  output logic               ovf
);

  localparam int               CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_ones     = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   prem_q, prem_d;      // partial remainder, always < |b|
  logic [WIDTH-1:0]   dvd_q, dvd_d;        // low dividend bits out, quotient bits in
  logic [WIDTH-1:0]   bmag_q, bmag_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               div_zero_q, div_zero_d;
  logic               ovf_q, ovf_d;

  logic [2*WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_diff;
  logic               w_q_bit;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] c_min_mag = {1'b1, {(WIDTH-1){1'b0}}};
  logic sign_a_q, sign_a_d;
  logic neg_q, neg_d;                      // quotient must be negated

  assign w_a_mag = a[2*WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
`endif

  // Trial subtract of the shifted partial remainder. The shifted value is at
  // most 2*|b|-1, so the sign bit of the (WIDTH+1)-bit difference is exact.
  assign w_diff  = {prem_q, dvd_q[WIDTH-1]} - {1'b0, bmag_q};
  assign w_q_bit = ~w_diff[WIDTH];

  // Next-state and datapath update for every register
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    bmag_d     = bmag_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
`ifdef DIV_SIGNED_EN
    sign_a_d   = sign_a_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (load) begin
          count_d    = '0;
          bmag_d     = w_b_mag;
          prem_d     = w_a_mag[2*WIDTH-1:WIDTH];
          dvd_d      = w_a_mag[WIDTH-1:0];
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
`ifdef DIV_SIGNED_EN
          sign_a_d   = a[2*WIDTH-1];
          neg_d      = a[2*WIDTH-1] ^ b[WIDTH-1];
`endif
          if (b == '0) begin
            div_zero_d = 1'b1;
            quot_d     = c_ones;
            rem_d      = a[WIDTH-1:0];
            state_d    = S_DONE;
          end else if (w_a_mag[2*WIDTH-1:WIDTH] >= w_b_mag) begin
            // Quotient magnitude would need more than WIDTH bits
            ovf_d   = 1'b1;
            quot_d  = c_ones;
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prem_d  = w_q_bit ? w_diff[WIDTH-1:0] : {prem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        dvd_d   = {dvd_q[WIDTH-2:0], w_q_bit};
        count_d = count_q + 1'b1;
        if (count_q == c_last_cnt) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
`ifdef DIV_SIGNED_EN
        // Only -2^(WIDTH-1) may use the full magnitude range
        if (dvd_q[WIDTH-1] && !(neg_q && (dvd_q == c_min_mag))) begin
          ovf_d  = 1'b1;
          quot_d = c_ones;
          rem_d  = '0;
        end else begin
          quot_d = neg_q ? -dvd_q : dvd_q;
          rem_d  = sign_a_q ? -prem_q : prem_q;
        end
`else
        quot_d = dvd_q;
        rem_d  = prem_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      bmag_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
      sign_a_q   <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      bmag_q     <= bmag_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
`ifdef DIV_SIGNED_EN
      sign_a_q   <= sign_a_d;
      neg_q      <= neg_d;
`endif
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider. Expected results come from
//             a behavioural model and are queued at load time, then compared
//             when done pulses. Honours DIV_SIGNED_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W        = 32;
  localparam int LAT_FULL = W + 2;
  localparam int BUSY_CYC = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    logic         sc;   // short-circuit path
  } exp_t;

  logic           clk;
  logic           rst;
  logic           load;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           div_zero;
  logic           ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t last_e;

  seq_divider #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference using native division
  function automatic exp_t model(input logic [2*W-1:0] aa, input logic [W-1:0] bb);
    exp_t           e;
    logic           sa;
    logic           sb_;
    logic [2*W-1:0] am;
    logic [2*W-1:0] bm;
    logic [2*W-1:0] qm;
    logic [2*W-1:0] rm;
    logic [W-1:0]   bneg;
    logic [W-1:0]   qlo;
    logic [W-1:0]   rlo;
    e = '0;
`ifdef DIV_SIGNED_EN
    sa  = aa[2*W-1];
    sb_ = bb[W-1];
`else
    sa  = 1'b0;
    sb_ = 1'b0;
`endif
    am   = sa ? -aa : aa;
    bneg = -bb;
    bm   = {32'd0, (sb_ ? bneg : bb)};
    if (bb == '0) begin
      e.dz = 1'b1; e.q = '1; e.r = aa[W-1:0]; e.sc = 1'b1;
    end else begin
      qm  = am / bm;
      rm  = am % bm;
      qlo = qm[W-1:0];
      rlo = rm[W-1:0];
      if (qm > 64'h0000_0000_FFFF_FFFF) begin
        e.ov = 1'b1; e.q = '1; e.r = '0; e.sc = 1'b1;
`ifdef DIV_SIGNED_EN
      end else if (qm >= 64'h8000_0000 && !((sa ^ sb_) && qm == 64'h8000_0000)) begin
        e.ov = 1'b1; e.q = '1; e.r = '0;
`endif
      end else begin
        e.q = (sa ^ sb_) ? -qlo : qlo;
        e.r = sa ? -rlo : rlo;
      end
    end
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("quot", {32'd0, quot}, {32'd0, mon_e.q});
        check("rem", {32'd0, rem}, {32'd0, mon_e.r});
        check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        check("ovf", {63'd0, ovf}, {63'd0, mon_e.ov});
      end
    end
  end

  // Drive a load at the current time and queue its expected result
  task automatic launch(input logic [2*W-1:0] aa, input logic [W-1:0] bb, output exp_t e);
    a    = aa;
    b    = bb;
    load = 1'b1;
    e    = model(aa, bb);
    sb.push_back(e);
  endtask

  // Drop load after edge 0, then wait (bounded) for done; optionally pulse
  // a second load while busy
  task automatic wait_done(input exp_t e, input int pulse_at);
    int lat;
    int busy_cnt;
    lat      = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      if (lat == 0) load = 1'b0;
      lat++;
      if (busy) busy_cnt++;
      if (lat == pulse_at) begin
        a = 64'd9; b = 32'd3; load = 1'b1;
      end
      if (lat == pulse_at + 1) load = 1'b0;
    end while (!done && lat < 100);
    check("latency", 64'(lat), e.sc ? 64'd1 : 64'(LAT_FULL));
    check("busy_cycles", 64'(busy_cnt), e.sc ? 64'd0 : 64'(BUSY_CYC));
  endtask

  task automatic op(input logic [2*W-1:0] aa, input logic [W-1:0] bb);
    exp_t e;
    @(negedge clk);
    launch(aa, bb, e);
    wait_done(e, -10);
    last_e = e;
  endtask

  initial begin
    exp_t e;
    int   dcnt;
    logic [W-1:0] rb;
    logic [W-1:0] rh;
    rst  = 1'b1;
    load = 1'b0;
    a    = '0;
    b    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_quot", {32'd0, quot}, 64'd0);
    check("rst_rem", {32'd0, rem}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    rst = 1'b0;

    // Basic division, then pulse width and hold behaviour
    op(64'd100, 32'd7);
    check("q_100_7", {32'd0, quot}, 64'd14);
    check("r_100_7", {32'd0, rem}, 64'd2);
    @(negedge clk);
    check("done_pulse_width", {63'd0, done}, 64'd0);
    repeat (3) @(negedge clk);
    check("quot_held", {32'd0, quot}, {32'd0, last_e.q});

    // Short-circuit paths and wide quotient
    op(64'h1234, 32'd0);
    op(64'h1_0000_0000, 32'd1);
    op(64'hFFFF_FFFF, 32'd1);
    op(64'd0, 32'd5);
    op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);
`ifdef DIV_SIGNED_EN
    op(-64'sd100, 32'd7);
    check("q_m100_7", {32'd0, quot}, 64'hFFFF_FFF2);
    check("r_m100_7", {32'd0, rem}, 64'hFFFF_FFFE);
    op(64'd100, -32'sd7);
    check("q_100_m7", {32'd0, quot}, 64'hFFFF_FFF2);
    check("r_100_m7", {32'd0, rem}, 64'd2);
    op(-64'sd2147483648, 32'd1);
    op(64'd2147483648, 32'd1);
    op(-64'sd100, -32'sd7);
`endif

    // Load while busy is ignored; back-to-back load in the done cycle
    @(negedge clk);
    launch(64'd100, 32'd7, e);
    wait_done(e, 5);
    check("ignored_q", {32'd0, quot}, 64'd14);
    launch(64'd9, 32'd3, e);
    wait_done(e, -10);
    check("b2b_q", {32'd0, quot}, 64'd3);
    check("b2b_r", {32'd0, rem}, 64'd0);

    // Random operands, mixing in-range and overflowing dividends
    for (int i = 0; i < 12; i++) begin
      rb = $urandom;
      if (rb == '0) rb = 32'd1;
      rh = (i % 3 == 0) ? $urandom : ($urandom % rb);
      op({rh, 32'($urandom)}, rb);
    end

    // Reset in the middle of a calculation
    @(negedge clk);
    launch(64'd100, 32'd7, e);
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_quot", {32'd0, quot}, 64'd0);
    check("midrst_rem", {32'd0, rem}, 64'd0);
    sb.delete();
    rst  = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("no_done_after_rst", 64'(dcnt), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
